axis_packet_demux: RTL
======================

Name: axis_packet_demux

Overview:
- Splits one AXI-Stream input into up to four AXI-Stream outputs, one whole packet at a time.
- The first beat of each input packet is a routing header. Its low 2 bits select the destination port. The header is consumed and not forwarded.
- Payload beats go through a one-deep register stage to the selected output.
- Sits at the receive end of a merged debug link and restores per-channel streams.

Parameters:
- NUM_INTERFACES, 2, number of active outputs (1..4). Outputs at or above this index are tied to 0.
- PORT_WIDTH, 8, tdata width in bits (minimum 2).
- DROP_CNT_WIDTH, 16, width of the drop and runt counters.

Ports:
- axis_aclk  in  1  single clock; all logic on its rising edge.
- axis_areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  PORT_WIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input last beat.
- s_axis_tready  out  1  input ready.
- mNN_axis_tdata  out  PORT_WIDTH  output data, NN = 00..03.
- mNN_axis_tvalid  out  1  output valid, NN = 00..03.
- mNN_axis_tlast  out  1  output last, NN = 00..03.
- mNN_axis_tready  in  1  output ready, NN = 00..03.
- drop_count  out  DROP_CNT_WIDTH  packets discarded due to an invalid destination.
- runt_count  out  DROP_CNT_WIDTH  header-only packets (header beat carries tlast).

Behaviour:
- Reset values:
  - state = HEADER; dest_q = 0.
  - All mNN_axis_tvalid/tlast/tdata = 0.
  - drop_count = 0; runt_count = 0.
  - s_axis_tready = 0 during the reset cycle.
- Input handshake: a beat is accepted when s_axis_tvalid & s_axis_tready.
- State machine:
  - HEADER:
    - s_axis_tready = 1.
    - On accept with tlast = 1: runt_count += 1, stay in HEADER.
    - On accept with tlast = 0: dest_q <= tdata[1:0].
    - If dest < NUM_INTERFACES, go to FORWARD; otherwise go to DROP.
  - FORWARD:
    - s_axis_tready = ~out_valid[dest_q] | mNN_axis_tready[dest_q].
    - An accepted beat loads the dest_q output register (tdata, tlast) and sets its valid.
    - On an accepted tlast beat, go to HEADER.
  - DROP:
    - s_axis_tready = 1; beats are discarded.
    - On an accepted tlast beat: drop_count += 1, go to HEADER.
- Output registers, one per port:
  - valid clears when tready & valid and no new beat is loaded in the same cycle.
  - Simultaneous drain and load: the register takes the new beat and valid stays 1, giving full throughput.
  - tdata and tlast hold while valid & ~tready (AXIS stability rule).
- Latency: an accepted payload beat appears on the output the next cycle. Throughput is one beat per cycle when the destination tready is held high.
- Isolation: non-selected outputs never receive beats. A stalled output blocks only the input, never other outputs' drains.
- The next header may be accepted in the cycle after the last payload beat is accepted, while that last beat is still held in its output register.
- Counters saturate at all-ones; they never wrap.
- Reset mid-packet:
  - Output registers are cleared and the held beats are lost.
  - The state machine returns to HEADER.
  - The first input beat after reset is treated as a header, even if it is mid-packet upstream. This is documented and required behaviour.
- With NUM_INTERFACES = 1, dest values 1..3 go to DROP.

Decomposition:
- Package axis_debug_pkg:
  - typedef enum {HEADER, FORWARD, DROP} demux_state_t.
  - localparam MAX_INTERFACES = 4.
  - localparam DEST_BITS = 2.
- Sub-module axis_out_reg (one-deep valid/ready holding register, PORT_WIDTH+1 bits), instanced per output in a generate loop bounded by NUM_INTERFACES.

Test Plan:
- Header 0x01, payload 0xA0, 0xA1, 0xA2 (tlast), all readies 1 -> m01 outputs A0, A1, A2 on cycles +1..+3 with tlast on A2; m00/m02/m03 tvalid stay 0.
- NUM_INTERFACES = 2, header 0x03, payload 0x10, 0x11 (tlast) -> no output valid; drop_count = 1; the next header 0x00 and payload 0x55 (tlast) appear on m00.
- Header 0x02 with tlast = 1 -> runt_count = 1, no output activity, state remains HEADER.
- Route to m00 with m00_axis_tready = 0 for 5 cycles, 4-beat packet -> s_axis_tready drops after one beat; m00 tdata stays stable; all 4 beats delivered in order once ready rises.
- Back-to-back packets to 00 then 01 -> m01 starts receiving 2 cycles after m00 last is accepted, with no bubble beyond the header.
- Assert axis_areset during beat 2 of a 4-beat packet -> all tvalid are 0 the next cycle, counters are 0, and the next input beat is parsed as a header.

Source files
------------

// File: rtl/axis_debug_pkg.sv
// Shared types and constants for the debug-link AXI-Stream demux.
package axis_debug_pkg;

  localparam int MAX_INTERFACES = 4;
  localparam int DEST_BITS      = 2;

  typedef enum logic [1:0] {
    HEADER,
    FORWARD,
    DROP
  } demux_state_t;

endpackage : axis_debug_pkg

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream holding register. A load may coincide with a drain,
// which keeps the output at full throughput.
module axis_out_reg #(
  parameter int WIDTH = 9
) (
  input  logic             axis_aclk,
  input  logic             axis_areset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             tready,
  output logic             tvalid,
  output logic [WIDTH-1:0] tdata
);

  // NOTE: state is written with <= so every register samples pre-edge values;
  // blocking assignments here would make results depend on process order.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      tvalid <= 1'b0;
      // NOTE: the payload register is reset too, because idle outputs must
      // read as zero; plain data storage would normally be left unreset.
      tdata  <= '0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule : axis_out_reg

// File: rtl/axis_packet_demux.sv
// Routes whole AXI-Stream packets to one of up to four outputs, selected by
// the low bits of a header beat that is consumed and not forwarded.
module axis_packet_demux
  import axis_debug_pkg::*;
#(
  parameter int NUM_INTERFACES = 2,
  parameter int PORT_WIDTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,

  input  logic [PORT_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,

  output logic [PORT_WIDTH-1:0]     m00_axis_tdata,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,

  output logic [PORT_WIDTH-1:0]     m01_axis_tdata,
  output logic                      m01_axis_tvalid,
  output logic                      m01_axis_tlast,
  input  logic                      m01_axis_tready,

  output logic [PORT_WIDTH-1:0]     m02_axis_tdata,
  output logic                      m02_axis_tvalid,
  output logic                      m02_axis_tlast,
  input  logic                      m02_axis_tready,

  output logic [PORT_WIDTH-1:0]     m03_axis_tdata,
  output logic                      m03_axis_tvalid,
  output logic                      m03_axis_tlast,
  input  logic                      m03_axis_tready,

  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic [DROP_CNT_WIDTH-1:0] runt_count
);

  demux_state_t                state, state_next;
  logic [DEST_BITS-1:0]        dest_q;
  logic                        ready_int;
  logic                        accept;
  logic                        hdr_in_range;

  logic [MAX_INTERFACES-1:0]   out_valid;
  logic [MAX_INTERFACES-1:0]   out_last;
  logic [MAX_INTERFACES-1:0]   out_ready;
  logic [PORT_WIDTH-1:0]       out_data [MAX_INTERFACES];

  assign out_ready = {m03_axis_tready, m02_axis_tready,
                      m01_axis_tready, m00_axis_tready};

  assign hdr_in_range = int'(s_axis_tdata[DEST_BITS-1:0]) < NUM_INTERFACES;

  // In FORWARD only the selected output can back-pressure the input.
  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no
    // latch is inferred for combinational outputs.
    ready_int = 1'b0;
    case (state)
      HEADER:  ready_int = 1'b1;
      FORWARD: ready_int = ~out_valid[dest_q] | out_ready[dest_q];
      DROP:    ready_int = 1'b1;
      default: ready_int = 1'b0;
    endcase
  end

  assign s_axis_tready = ready_int & ~axis_areset;
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_next = state;
    case (state)
      HEADER: begin
        if (accept && !s_axis_tlast)
          state_next = hdr_in_range ? FORWARD : DROP;
      end
      FORWARD, DROP: begin
        if (accept && s_axis_tlast)
          state_next = HEADER;
      end
      default: state_next = HEADER;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state      <= HEADER;
      dest_q     <= '0;
      drop_count <= '0;
      runt_count <= '0;
    end else begin
      state <= state_next;
      if (state == HEADER && accept && !s_axis_tlast)
        dest_q <= s_axis_tdata[DEST_BITS-1:0];
      if (state == HEADER && accept && s_axis_tlast && runt_count != '1)
        runt_count <= runt_count + 1'b1;
      if (state == DROP && accept && s_axis_tlast && drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_INTERFACES; i++) begin : g_out
    logic                  load;
    logic [PORT_WIDTH:0]   word;

    assign load = (state == FORWARD) && accept && (dest_q == DEST_BITS'(i));

    axis_out_reg #(
      .WIDTH (PORT_WIDTH + 1)
    ) u_out_reg (
      .axis_aclk   (axis_aclk),
      .axis_areset (axis_areset),
      .load        (load),
      .load_data   ({s_axis_tlast, s_axis_tdata}),
      .tready      (out_ready[i]),
      .tvalid      (out_valid[i]),
      .tdata       (word)
    );

    assign out_last[i] = word[PORT_WIDTH];
    assign out_data[i] = word[PORT_WIDTH-1:0];
  end

  // Outputs beyond the configured count are permanently idle.
  for (genvar i = NUM_INTERFACES; i < MAX_INTERFACES; i++) begin : g_tie
    assign out_valid[i] = 1'b0;
    assign out_last[i]  = 1'b0;
    assign out_data[i]  = '0;
  end

  assign m00_axis_tdata  = out_data[0];
  assign m00_axis_tvalid = out_valid[0];
  assign m00_axis_tlast  = out_last[0];
  assign m01_axis_tdata  = out_data[1];
  assign m01_axis_tvalid = out_valid[1];
  assign m01_axis_tlast  = out_last[1];
  assign m02_axis_tdata  = out_data[2];
  assign m02_axis_tvalid = out_valid[2];
  assign m02_axis_tlast  = out_last[2];
  assign m03_axis_tdata  = out_data[3];
  assign m03_axis_tvalid = out_valid[3];
  assign m03_axis_tlast  = out_last[3];

endmodule : axis_packet_demux
